// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand-fetch stage in front of the 32-bit ALU. It holds the
//   architectural register file, which has 2**ADDR_W entries of DATA_W bits.
//   Each issue reads two source registers. The second operand is either a
//   register or the immediate. A, B and op go to the ALU from a registered
//   output stage.
//
// Handshake (valid/ready):
//   - A transfer happens on a rising edge where valid && ready.
//   - A producer holding valid=1 keeps its payload stable until the transfer.
//   - Ready may depend combinationally on downstream ready. It never depends
//     on in_valid.
//   - On the issue side, in_ready = !out_valid || out_ready. A new issue can
//     therefore replace an output that is consumed in the same cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data    write-back port, one write per cycle, never stalled
//   in_valid / in_ready        issue handshake
//   in_rn, in_rm               source register indices for A and B
//   in_use_imm, in_imm         select immediate as B
//   in_op                      ALU opcode, passed through
//   out_valid / out_ready      output handshake toward the ALU
//   A, B, op                   registered operands and opcode
//
// Configuration macro
//   RF_BYPASS_EN  When defined, a write to the index being read in the same
//                 accept cycle forwards wr_data into the captured operand.
//                 When undefined, operands always come from the pre-edge
//                 register-file contents.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   op
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] b_sel;
  logic              accept;

  // Register file. Every entry is writable, and no entry is hardwired to
  // zero. Write-back is independent of the issue handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // Read ports, with optional same-cycle forwarding from write-back.
  always_comb begin
    rd_a = rf[in_rn];
    rd_b = rf[in_rm];
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_addr == in_rn)) rd_a = wr_data;
    if (wr_en && (wr_addr == in_rm)) rd_b = wr_data;
`endif
  end

  // With the immediate selected, rd_b is discarded here. A write to in_rm
  // therefore has no effect on B.
  assign b_sel    = in_use_imm ? in_imm : rd_b;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register. The payload changes only on accept. A stall
  // (out_valid && !out_ready) blocks accept, so the captured operands stay
  // fixed snapshots even while the register file is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      op        <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      A         <= rd_a;
      B         <= b_sel;
      op        <= in_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int OP_W   = 4;
  localparam int PW     = 2*DATA_W + OP_W;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rn;
  logic [ADDR_W-1:0] in_rm;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [OP_W-1:0]   op;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] rf_model [16];
  logic [PW-1:0]     exp_q [$];

  alu_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .op         (op)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    rf_model[a] = d;
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rn, input logic [ADDR_W-1:0] rm,
                       input logic use_imm, input logic [DATA_W-1:0] imm,
                       input logic [OP_W-1:0] o);
    in_valid = 1'b1; in_rn = rn; in_rm = rm; in_use_imm = use_imm;
    in_imm = imm; in_op = o;
    step();
    in_valid = 1'b0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    exp_q.delete();
  endtask

  initial begin
    logic [PW-1:0] e;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_rn = '0; in_rm = '0; in_use_imm = 1'b0;
    in_imm = '0; in_op = '0; out_ready = 1'b1;
    reset_model();

    // reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_A", 64'(A), 64'd0);
    check("rst_B", 64'(B), 64'd0);
    check("rst_op", 64'(op), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step(); step();
    rst_n = 1'b1;

    // issue from freshly reset registers
    issue(4'd3, 4'd7, 1'b0, 32'h0, 4'h0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_A", 64'(A), 64'd0);
    check("first_B", 64'(B), 64'd0);

    // register read
    wr(4'd1, 32'h9C000038);
    wr(4'd2, 32'h70000003);
    check("idle_valid", 64'(out_valid), 64'd0);
    issue(4'd1, 4'd2, 1'b0, 32'h0, 4'h1);
    check("rr_valid", 64'(out_valid), 64'd1);
    check("rr_A", 64'(A), 64'h9C000038);
    check("rr_B", 64'(B), 64'h70000003);
    check("rr_op", 64'(op), 64'h1);

    // immediate; in_rm=2 would give 0x70000003 if it leaked through
    issue(4'd1, 4'd2, 1'b1, 32'h00000005, 4'h0);
    check("imm_A", 64'(A), 64'h9C000038);
    check("imm_B", 64'(B), 64'h00000005);
    check("imm_op", 64'(op), 64'h0);

    // stall for 3 cycles while r1 is rewritten and another issue waits
    out_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFFFFFFFF;
    in_valid = 1'b1; in_rn = 4'd2; in_rm = 4'd2; in_use_imm = 1'b0; in_op = 4'h7;
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready_hold", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_A", 64'(A), 64'h9C000038);
      check("stall_B", 64'(B), 64'h00000005);
      check("stall_op", 64'(op), 64'h0);
    end
    rf_model[1] = 32'hFFFFFFFF;
    wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("consume_valid", 64'(out_valid), 64'd0);
    issue(4'd1, 4'd0, 1'b0, 32'h0, 4'h2);
    check("fresh_A", 64'(A), 64'hFFFFFFFF);
    check("fresh_B", 64'(B), 64'h0);

    // same-cycle write and read of r4 (prior value 0)
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h12345678;
    issue(4'd4, 4'd4, 1'b0, 32'h0, 4'h3);
    rf_model[4] = 32'h12345678;
    wr_en = 1'b0;
`ifdef RF_BYPASS_EN
    check("byp_A", 64'(A), 64'h12345678);
    check("byp_B", 64'(B), 64'h12345678);
`else
    check("nobyp_A", 64'(A), 64'h0);
    check("nobyp_B", 64'(B), 64'h0);
`endif
    issue(4'd4, 4'd0, 1'b1, 32'hA5A5A5A5, 4'h4);
    check("later_A", 64'(A), 64'h12345678);
    check("later_B", 64'(B), 64'hA5A5A5A5);

    // streaming: load distinct values, then 16 back-to-back issues
    for (int i = 0; i < 16; i++) wr(4'(i), 32'h10000000 + 32'(i) * 32'h00010011);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_rn = 4'(i); in_rm = 4'(15 - i);
      in_use_imm = 1'b0; in_op = 4'(i);
      exp_q.push_back({rf_model[i], rf_model[15 - i], 4'(i)});
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      if (exp_q.size() == 0) begin
        check("stream_q_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("stream_A", 64'(A), 64'(e[PW-1 -: DATA_W]));
        check("stream_B", 64'(B), 64'(e[OP_W +: DATA_W]));
        check("stream_op", 64'(op), 64'(e[OP_W-1:0]));
      end
    end

    // issue still pending, reset pulsed away from the clock edge
    in_valid = 1'b1; in_rn = 4'd5; in_rm = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_A", 64'(A), 64'd0);
    check("midrst_B", 64'(B), 64'd0);
    check("midrst_op", 64'(op), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    reset_model();
    step();
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;

    // every register reads zero after reset
    for (int i = 0; i < 8; i++) begin
      issue(4'(2*i), 4'(2*i + 1), 1'b0, 32'h0, 4'hF);
      check("post_rst_A", 64'(A), 64'd0);
      check("post_rst_B", 64'(B), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
